// File: rtl/kernel_fifo_src.sv
`default_nettype none
// ============================================================================
// Module   : kernel_fifo_src
// Brief    : ROM-backed ap_fifo source feeding one dataset per ap_ctrl_hs run.
//            Optional macro FIFO_SRC_THROTTLE_EN adds LFSR-driven output bubbles.
// Revision : 1.0 - initial release
// ============================================================================
module kernel_fifo_src #(
    parameter int    DATA_WIDTH     = 32,
    parameter int    DATA_SIZE      = 64,
    parameter int    DATASET_NUM    = 8,
    parameter int    ROM_ADDR_WIDTH = $clog2(DATA_SIZE * DATASET_NUM),
    parameter string ROM_INIT_FILE  = ""
) (
    input  logic                           ap_clk,
    input  logic                           ap_rst,
    input  logic                           ap_start,
    input  logic                           ap_done,
    output logic [DATA_WIDTH-1:0]          src_dout,
    output logic                           src_empty_n,
    input  logic                           src_read,
    output logic [$clog2(DATASET_NUM)-1:0] dataset_idx,
    output logic                           underrun
);

    localparam int CNT_W     = $clog2(DATA_SIZE + 1);
    localparam int IDX_W     = $clog2(DATASET_NUM);

    localparam logic [1:0] S_IDLE      = 2'd0;
    localparam logic [1:0] S_LOAD      = 2'd1;
    localparam logic [1:0] S_STREAM    = 2'd2;
    localparam logic [1:0] S_WAIT_DONE = 2'd3;

    logic [1:0]                r_state;
    logic [1:0]                w_next_state;
    logic [CNT_W-1:0]          r_rd_cnt;
    logic [CNT_W-1:0]          r_pop_cnt;
    logic [1:0]                r_occ;
    logic                      r_rom_vld;
    logic [DATA_WIDTH-1:0]     r_rom_q;
    logic [DATA_WIDTH-1:0]     r_buf0;
    logic [DATA_WIDTH-1:0]     r_buf1;
    logic [IDX_W-1:0]          r_idx;
    logic                      r_underrun;
    logic                      w_avail;
    logic                      w_pop;
    logic                      w_rd_en;
    logic                      w_room;
    logic                      w_start;
    logic                      w_abort;
    logic                      w_last_pop;
    logic                      w_advance;
    logic                      w_throttle;
    logic [2:0]                w_credit;
    logic [ROM_ADDR_WIDTH-1:0] w_base;
    logic [ROM_ADDR_WIDTH-1:0] w_rd_addr;

`ifdef FIFO_SRC_THROTTLE_EN
    logic [7:0] r_lfsr;

    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            r_lfsr <= 8'hA5;
        end else begin
            r_lfsr <= {r_lfsr[6:0], r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3]};
        end
    end

    assign w_throttle = r_lfsr[0];
`else
    assign w_throttle = 1'b0;
`endif

    assign w_base     = ROM_ADDR_WIDTH'(r_idx) * ROM_ADDR_WIDTH'(DATA_SIZE);
    assign w_rd_addr  = (r_state == S_IDLE) ? w_base : w_base + ROM_ADDR_WIDTH'(r_rd_cnt);
    assign w_avail    = (r_state == S_STREAM) && (r_occ != 2'd0) && !w_throttle;
    assign w_pop      = w_avail && src_read;
    assign w_start    = (r_state == S_IDLE) && ap_start;
    assign w_abort    = ap_done && ((r_state == S_LOAD) || (r_state == S_STREAM));
    assign w_last_pop = w_pop && (r_pop_cnt == CNT_W'(DATA_SIZE - 1));
    assign w_advance  = w_abort || ((r_state == S_WAIT_DONE) && ap_done);

    // Words buffered plus the one in the ROM register, after this cycle's pop,
    // must leave a slot for a read issued now.
    assign w_credit = {1'b0, r_occ} + {2'b00, r_rom_vld} - {2'b00, w_pop};
    assign w_room   = (w_credit <= 3'd1) && (r_rd_cnt < CNT_W'(DATA_SIZE));

    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:      if (ap_start) w_next_state = S_LOAD;
            S_LOAD: begin
                if (ap_done)        w_next_state = S_IDLE;
                else if (r_rom_vld) w_next_state = S_STREAM;
            end
            S_STREAM: begin
                if (ap_done)         w_next_state = S_IDLE;
                else if (w_last_pop) w_next_state = S_WAIT_DONE;
            end
            S_WAIT_DONE: if (ap_done) w_next_state = S_IDLE;
            default:     w_next_state = S_IDLE;
        endcase
    end

    always_comb begin
        src_empty_n = w_avail;
        w_rd_en     = 1'b0;
        case (r_state)
            S_IDLE:   w_rd_en = ap_start;
            S_LOAD,
            S_STREAM: w_rd_en = !ap_done && w_room;
            default:  w_rd_en = 1'b0;
        endcase
    end

    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            r_rd_cnt   <= '0;
            r_pop_cnt  <= '0;
            r_occ      <= 2'd0;
            r_rom_vld  <= 1'b0;
            r_buf0     <= '0;
            r_buf1     <= '0;
            r_idx      <= '0;
            r_underrun <= 1'b0;
        end else begin
            if (src_read && !src_empty_n) begin
                r_underrun <= 1'b1;
            end

            if (w_start) begin
                r_rd_cnt  <= CNT_W'(1);
                r_pop_cnt <= '0;
            end else begin
                if (w_rd_en) r_rd_cnt  <= r_rd_cnt + 1'b1;
                if (w_pop)   r_pop_cnt <= r_pop_cnt + 1'b1;
            end

            if (w_abort) begin
                r_occ     <= 2'd0;
                r_rom_vld <= 1'b0;
            end else begin
                r_rom_vld <= w_rd_en;
                case ({r_rom_vld, w_pop})
                    2'b11: begin
                        if (r_occ == 2'd1) begin
                            r_buf0 <= r_rom_q;
                        end else begin
                            r_buf0 <= r_buf1;
                            r_buf1 <= r_rom_q;
                        end
                    end
                    2'b01: begin
                        r_buf0 <= r_buf1;
                        r_occ  <= r_occ - 1'b1;
                    end
                    2'b10: begin
                        if (r_occ == 2'd0) r_buf0 <= r_rom_q;
                        else               r_buf1 <= r_rom_q;
                        r_occ <= r_occ + 1'b1;
                    end
                    default: ;
                endcase
            end

            if (w_advance) begin
                r_idx <= (r_idx == IDX_W'(DATASET_NUM - 1)) ? '0 : r_idx + 1'b1;
            end
        end
    end

    // ROM content equals its address.
    always_ff @(posedge ap_clk) begin
        if (w_rd_en) r_rom_q <= DATA_WIDTH'(w_rd_addr);
    end

    assign src_dout    = r_buf0;
    assign dataset_idx = r_idx;
    assign underrun    = r_underrun;

endmodule
`default_nettype wire

// File: tb/tb_kernel_fifo_src.sv
`default_nettype none
// ============================================================================
// Module   : tb_kernel_fifo_src
// Brief    : Scoreboard bench for kernel_fifo_src (ROM word == address).
// Revision : 1.0 - initial release
// ============================================================================
module tb_kernel_fifo_src;

    localparam int DW = 32;
    localparam int DS = 64;
    localparam int DN = 8;

    logic          ap_clk = 1'b0;
    logic          ap_rst;
    logic          ap_start;
    logic          ap_done;
    logic          src_read;
    logic [DW-1:0] src_dout;
    logic          src_empty_n;
    logic [2:0]    dataset_idx;
    logic          underrun;

    int            n_vec = 0;
    int            n_err = 0;
    int            exp_idx = 0;
    logic [DW-1:0] exp_q[$];

    kernel_fifo_src #(
        .DATA_WIDTH  (DW),
        .DATA_SIZE   (DS),
        .DATASET_NUM (DN)
    ) u_dut (
        .ap_clk      (ap_clk),
        .ap_rst      (ap_rst),
        .ap_start    (ap_start),
        .ap_done     (ap_done),
        .src_dout    (src_dout),
        .src_empty_n (src_empty_n),
        .src_read    (src_read),
        .dataset_idx (dataset_idx),
        .underrun    (underrun)
    );

    always #5 ap_clk = ~ap_clk;

    task automatic step();
        @(posedge ap_clk);
        #1;
    endtask

    task automatic load_exp(input int d, input int n);
        for (int k = 0; k < n; k++) exp_q.push_back(DW'(d * DS + k));
    endtask

    task automatic kick();
        ap_start = 1'b1;
        step();
        ap_start = 1'b0;
    endtask

    task automatic end_round();
        ap_done = 1'b1;
        step();
        ap_done = 1'b0;
        exp_idx = (exp_idx + 1) % DN;
    endtask

    // Kernel-like consumer: pops only while data is offered, scoring each word.
    task automatic stream_words(input int n, input bit alt);
        int            pops = 0;
        int            cyc  = 0;
        bit            ph   = 1'b1;
        bit            hold = 1'b0;
        logic [DW-1:0] prev = '0;
        logic [DW-1:0] e;
        while (pops < n && cyc < 1000) begin
`ifndef FIFO_SRC_THROTTLE_EN
            if (!alt && pops > 0) begin
                n_vec++;
                if (src_empty_n !== 1'b1) begin
                    n_err++;
                    $display("FAIL bubble: src_empty_n=%b after %0d pops, want 1", src_empty_n, pops);
                end
            end
`endif
            src_read = src_empty_n && (!alt || ph);
            ph = !ph;
            if (src_read) begin
                e = 'x;
                if (exp_q.size() > 0) e = exp_q.pop_front();
                n_vec++;
                if (src_dout !== e) begin
                    n_err++;
                    $display("FAIL word: src_dout=%0d want %0d (pop %0d)", src_dout, e, pops);
                end
                pops++;
                hold = 1'b0;
            end else begin
                if (hold && src_empty_n) begin
                    n_vec++;
                    if (src_dout !== prev) begin
                        n_err++;
                        $display("FAIL stable: src_dout=%0d want %0d", src_dout, prev);
                    end
                end
                hold = src_empty_n;
            end
            prev = src_dout;
            step();
            cyc++;
        end
        src_read = 1'b0;
        if (pops < n) begin
            n_vec++;
            n_err++;
            $display("FAIL stream_timeout: pops=%0d want %0d", pops, n);
        end
    endtask

    task automatic wait_avail();
        int lat = 0;
        while (!src_empty_n && lat < 50) begin
            step();
            lat++;
        end
        n_vec++;
        if (src_empty_n !== 1'b1) begin
            n_err++;
            $display("FAIL start_timeout: src_empty_n=%b want 1", src_empty_n);
        end
`ifndef FIFO_SRC_THROTTLE_EN
        n_vec++;
        if (lat > 2) begin
            n_err++;
            $display("FAIL latency: %0d cycles, want <= 2", lat);
        end
`endif
    endtask

    task automatic do_round(input bit alt);
        n_vec++;
        if (dataset_idx !== 3'(exp_idx)) begin
            n_err++;
            $display("FAIL round_idx: dataset_idx=%0d want %0d", dataset_idx, exp_idx);
        end
        load_exp(exp_idx, DS);
        kick();
        wait_avail();
        stream_words(DS, alt);
        n_vec++;
        if (src_empty_n !== 1'b0) begin
            n_err++;
            $display("FAIL drained: src_empty_n=%b want 0", src_empty_n);
        end
        end_round();
    endtask

    task automatic test_reset();
        ap_rst = 1'b1; ap_start = 1'b0; ap_done = 1'b0; src_read = 1'b0;
        repeat (3) step();
        n_vec += 4;
        if (src_empty_n !== 1'b0) begin n_err++; $display("FAIL rst_empty_n: %b want 0", src_empty_n); end
        if (src_dout !== '0)      begin n_err++; $display("FAIL rst_dout: %0d want 0", src_dout); end
        if (dataset_idx !== 3'd0) begin n_err++; $display("FAIL rst_idx: %0d want 0", dataset_idx); end
        if (underrun !== 1'b0)    begin n_err++; $display("FAIL rst_underrun: %b want 0", underrun); end
        ap_rst = 1'b0;
        step();
    endtask

    task automatic test_stream();
        do_round(1'b0);
        n_vec += 2;
        if (underrun !== 1'b0) begin
            n_err++;
            $display("FAIL stream_underrun: %b want 0", underrun);
        end
        if (dataset_idx !== 3'd1) begin
            n_err++;
            $display("FAIL stream_idx: %0d want 1", dataset_idx);
        end
    endtask

    task automatic test_rounds();
        for (int r = 1; r <= DN; r++) do_round(1'b0);
        n_vec++;
        if (dataset_idx !== 3'd1) begin
            n_err++;
            $display("FAIL wrap_idx: %0d want 1", dataset_idx);
        end
    endtask

    task automatic test_alternate();
        do_round(1'b1);
    endtask

    task automatic test_abort_and_reset();
        load_exp(exp_idx, 10);
        kick();
        wait_avail();
        stream_words(10, 1'b0);
`ifndef FIFO_SRC_THROTTLE_EN
        n_vec++;
        if (src_empty_n !== 1'b1) begin
            n_err++;
            $display("FAIL pre_abort: src_empty_n=%b want 1", src_empty_n);
        end
`endif
        end_round();
        n_vec += 2;
        if (src_empty_n !== 1'b0) begin n_err++; $display("FAIL abort_empty_n: %b want 0", src_empty_n); end
        if (dataset_idx !== 3'(exp_idx)) begin
            n_err++;
            $display("FAIL abort_idx: %0d want %0d", dataset_idx, exp_idx);
        end
        // Next dataset must start from its own first word.
        load_exp(exp_idx, 30);
        kick();
        wait_avail();
        stream_words(30, 1'b0);
        ap_rst = 1'b1;
        #2;
        n_vec += 3;
        if (src_empty_n !== 1'b0) begin n_err++; $display("FAIL arst_empty_n: %b want 0", src_empty_n); end
        if (dataset_idx !== 3'd0) begin n_err++; $display("FAIL arst_idx: %0d want 0", dataset_idx); end
        if (src_dout !== '0)      begin n_err++; $display("FAIL arst_dout: %0d want 0", src_dout); end
        step();
        ap_rst = 1'b0;
        exp_idx = 0;
        exp_q.delete();
        do_round(1'b0);
    endtask

    task automatic test_underrun();
        n_vec++;
        if (underrun !== 1'b0) begin n_err++; $display("FAIL pre_underrun: %b want 0", underrun); end
        src_read = 1'b1;
        step();
        src_read = 1'b0;
        n_vec++;
        if (underrun !== 1'b1) begin n_err++; $display("FAIL underrun_set: %b want 1", underrun); end
        repeat (5) step();
        n_vec++;
        if (underrun !== 1'b1) begin n_err++; $display("FAIL underrun_hold: %b want 1", underrun); end
        ap_rst = 1'b1;
        step();
        ap_rst = 1'b0;
        n_vec++;
        if (underrun !== 1'b0) begin n_err++; $display("FAIL underrun_clear: %b want 0", underrun); end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_rounds();
        test_alternate();
        test_abort_and_reset();
        test_underrun();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule
`default_nettype wire
